// File: rtl/oled_frame_scheduler_if.sv
// Pixel-stream bundle between the screen renderers, the scheduler and the OLED driver.
// master: renderers/driver side (drives requests and source pixels).
// slave:  the scheduler itself.
interface oled_frame_scheduler_if;
   localparam int unsigned PIX_W = 16;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned FC_W  = 8;

   logic             frame_begin;
   logic [SEL_W-1:0] sel_req;
   logic [PIX_W-1:0] src0_data;
   logic [PIX_W-1:0] src1_data;
   logic [PIX_W-1:0] src2_data;
   logic [PIX_W-1:0] src3_data;
   logic [PIX_W-1:0] oled_data;
   logic [SEL_W-1:0] active_sel;
   logic             busy;
   logic             switch_done;
   logic [FC_W-1:0]  frame_count;

   modport master (
      output frame_begin, sel_req, src0_data, src1_data, src2_data, src3_data,
      input  oled_data, active_sel, busy, switch_done, frame_count
   );

   modport slave (
      input  frame_begin, sel_req, src0_data, src1_data, src2_data, src3_data,
      output oled_data, active_sel, busy, switch_done, frame_count
   );
endinterface

// File: rtl/oled_frame_scheduler.sv
// Frame-synchronous source scheduler for the shared OLED pixel stream.
// Screen changes commit only on frame boundaries, with BLANK_FRAMES blank
// frames in between. Optional macro OLED_FADE_EN: during blanking, show the
// outgoing source progressively dimmed instead of black.
module oled_frame_scheduler #(
   parameter int unsigned BLANK_FRAMES = 2,
   parameter int unsigned TIMEOUT_CYC  = 65535
) (
   input  logic                  clk,
   input  logic                  reset_n,
   oled_frame_scheduler_if.slave bus
);
   localparam int unsigned PIX_W = 16;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned FC_W  = 8;
   localparam int unsigned BC_W  = 4;
   localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      SHOW      = 2'd0,
      WAIT_EDGE = 2'd1,
      BLANK     = 2'd2
   } state_t;

   state_t           state_q,   state_d;
   logic [SEL_W-1:0] active_q,  active_d;
   logic [SEL_W-1:0] target_q,  target_d;
   logic [BC_W-1:0]  blank_q,   blank_d;
   logic [TO_W-1:0]  timeout_q, timeout_d;
   logic             done_d;
   logic             busy_q;
   logic             done_q;
   logic [FC_W-1:0]  fc_q;
   logic             edge_hit;
   logic [PIX_W-1:0] pix_sel;
   logic [PIX_W-1:0] pix_blank;

   // State register plus all registered outputs; async reset discards any pending switch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= SHOW;
         active_q  <= '0;
         target_q  <= '0;
         blank_q   <= '0;
         timeout_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fc_q      <= '0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         target_q  <= target_d;
         blank_q   <= blank_d;
         timeout_q <= timeout_d;
         busy_q    <= (state_d != SHOW);
         done_q    <= done_d;
         if (bus.frame_begin) begin
            fc_q <= fc_q + FC_W'(1);
         end
      end
   end

   // Next-state logic: request capture, cancel, frame-edge/timeout switch, blank countdown.
   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      target_d  = target_q;
      blank_d   = blank_q;
      timeout_d = timeout_q;
      done_d    = 1'b0;
      edge_hit  = bus.frame_begin || (timeout_q == TO_W'(TIMEOUT_CYC - 1));
      case (state_q)
         SHOW: begin
            if (bus.sel_req != active_q) begin
               target_d  = bus.sel_req;
               timeout_d = '0;
               state_d   = WAIT_EDGE;
            end
         end
         WAIT_EDGE: begin
            if (bus.sel_req == active_q) begin
               // Cancel wins over a coincident frame edge.
               state_d = SHOW;
            end else begin
               target_d = bus.sel_req;
               if (edge_hit) begin
                  if (BLANK_FRAMES == 0) begin
                     active_d = target_d;
                     done_d   = 1'b1;
                     state_d  = SHOW;
                  end else begin
                     blank_d = BC_W'(BLANK_FRAMES);
                     state_d = BLANK;
                  end
               end else begin
                  timeout_d = timeout_q + TO_W'(1);
               end
            end
         end
         BLANK: begin
            target_d = bus.sel_req;
            if (bus.frame_begin) begin
               if (blank_q == BC_W'(1)) begin
                  // Commit even if the request returned to the old source.
                  active_d = target_d;
                  done_d   = 1'b1;
                  blank_d  = '0;
                  state_d  = SHOW;
               end else begin
                  blank_d = blank_q - BC_W'(1);
               end
            end
         end
         default: state_d = SHOW;
      endcase
   end

`ifdef OLED_FADE_EN
   logic [4:0] fade_k_full;
   logic [2:0] fade_k;

   // Fade depth grows by one step per blank frame, capped at 6.
   always_comb begin
      fade_k_full = 5'(BLANK_FRAMES) - 5'(blank_q) + 5'd1;
      fade_k      = (fade_k_full > 5'd6) ? 3'd6 : 3'(fade_k_full);
      pix_blank   = {pix_sel[15:11] >> fade_k, pix_sel[10:5] >> fade_k, pix_sel[4:0] >> fade_k};
   end
`else
   assign pix_blank = '0;
`endif

   // Output mux: zero-latency path from the committed source, blanked during BLANK.
   always_comb begin
      pix_sel = bus.src0_data;
      case (active_q)
         2'd0:    pix_sel = bus.src0_data;
         2'd1:    pix_sel = bus.src1_data;
         2'd2:    pix_sel = bus.src2_data;
         default: pix_sel = bus.src3_data;
      endcase
      bus.oled_data = (state_q == BLANK) ? pix_blank : pix_sel;
   end

   assign bus.active_sel  = active_q;
   assign bus.busy        = busy_q;
   assign bus.switch_done = done_q;
   assign bus.frame_count = fc_q;

endmodule

// File: doc/oled_frame_scheduler.md
Name: oled_frame_scheduler

Overview:
- Frame-synchronous scheduler for the shared OLED pixel stream. Arbitrates which of four screen sources (menu, volume bar, game, game-over) drives the single pixel_data input of the OLED driver.
- Screen changes requested by the state controller take effect only on frame boundaries, with a configurable number of blank frames in between. This prevents tearing and half-drawn screens.
- Sits between the per-screen renderers and the OLED driver, in the OLED pixel clock domain.

Parameters:
- BLANK_FRAMES, 2: number of full blank frames inserted between old and new source (0..15).
- TIMEOUT_CYC, 65535: cycles to wait for frame_begin before forcing the switch (driver stalled or in reset).

Ports:
- clk  input  1  OLED pixel clock (6.25 MHz)
- reset_n  input  1  asynchronous, active-low reset
- frame_begin  input  1  one-cycle pulse from OLED driver at start of each frame
- sel_req  input  2  requested source: 0 menu, 1 volume, 2 game, 3 game-over
- src0_data  input  16  RGB565 pixel from source 0
- src1_data  input  16  RGB565 pixel from source 1
- src2_data  input  16  RGB565 pixel from source 2
- src3_data  input  16  RGB565 pixel from source 3
- oled_data  output  16  pixel to OLED driver
- active_sel  output  2  source currently committed
- busy  output  1  high while a switch is pending or blanking
- switch_done  output  1  one-cycle pulse when active_sel changes
- frame_count  output  8  free-running frame counter

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=SHOW, active_sel=0, target=0, blank_cnt=0, timeout_cnt=0.
  - busy=0, switch_done=0, frame_count=0.
  - oled_data follows src0_data.
- oled_data is a combinational mux of registered state. Zero-latency path from srcN_data.
  - In SHOW and WAIT_EDGE: oled_data = src[active_sel].
  - In BLANK: oled_data = 16'h0000.
- frame_count increments on every frame_begin in every state and wraps 255->0.
- SHOW:
  - When sel_req != active_sel: target<=sel_req, timeout_cnt<=0, go to WAIT_EDGE.
  - busy rises the cycle after the request is seen.
- WAIT_EDGE (old source still shown):
  - If sel_req == active_sel, cancel: go to SHOW with busy=0 and no switch_done. Cancel takes priority over frame_begin in the same cycle.
  - Otherwise target<=sel_req every cycle.
  - On frame_begin, or timeout_cnt reaching TIMEOUT_CYC-1:
    - If BLANK_FRAMES=0: active_sel<=target, pulse switch_done, go to SHOW.
    - Else: blank_cnt<=BLANK_FRAMES, go to BLANK.
  - timeout_cnt counts up each cycle without frame_begin.
- BLANK:
  - target tracks sel_req every cycle (retarget without restarting the count).
  - On each frame_begin, blank_cnt decrements.
  - On the frame_begin where blank_cnt==1: active_sel<=target, switch_done=1 for exactly one cycle, go to SHOW.
  - If target equals the old active_sel at commit, still commit and pulse switch_done.
- Timing: blank period is exactly BLANK_FRAMES whole frames. active_sel changes the cycle after the qualifying frame_begin.
- busy=1 in WAIT_EDGE and BLANK, 0 in SHOW.
- Reset mid-switch: immediate return to the reset state. The pending target is discarded.

Optional Feature:
- Macro: OLED_FADE_EN.
- When defined: BLANK outputs the outgoing source dimmed instead of black.
  - k = BLANK_FRAMES - blank_cnt + 1, saturated at 6.
  - Output is {R[4:0]>>k, G[5:0]>>k, B[4:0]>>k} of src[active_sel].
- When undefined: BLANK outputs 16'h0000. No shifter logic is synthesised.

Test Plan:
- Reset: release reset_n with src0_data=16'hF800, sel_req=0 -> oled_data=16'hF800, active_sel=0, busy=0, frame_count=0.
- Basic switch, BLANK_FRAMES=2: sel_req 0->2 mid-frame, then three frame_begin pulses 1000 cycles apart.
  - oled_data=src0 until pulse 1, 0000 between pulses 1 and 3.
  - active_sel=2 and switch_done=1 one cycle after pulse 3.
  - busy drops with switch_done.
- Cancel: sel_req 0->1, then back to 0 before any frame_begin -> no BLANK, no switch_done, busy 1 then 0, oled_data=src0 throughout.
- Retarget during blank: sel_req 0->1, frame_begin, sel_req->3, two more frame_begin -> active_sel=3, exactly one switch_done pulse.
- Timeout: TIMEOUT_CYC=100, sel_req 0->1, frame_begin held low -> BLANK entered after 100 cycles. Subsequent frame_begins complete the switch.
- Wrap and async reset: 256 frame_begin pulses -> frame_count returns to 0. Assert reset_n mid-BLANK -> outputs at reset values within the same cycle (no clock edge needed).
